// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one DATA_LEN-bit word at a time and sends it
// as DATA_LEN/8 back-to-back UART 8N1 frames, least-significant byte first.
module fifo_uart_tx #(
    parameter int DATA_LEN     = 16,
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    output logic                read_en,
    input  logic [DATA_LEN-1:0] data_in,
    output logic                tx,
    output logic                busy,
    output logic [15:0]         words_sent
);

    localparam int NBYTES = DATA_LEN / 8;
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, START, DATA, STOP} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       baud_cnt;
    logic [2:0]          bit_cnt;
    logic [BW-1:0]       byte_cnt;
    logic [7:0]          shreg;
    logic [DATA_LEN-1:0] word_reg;
    logic                bit_done;
    logic                last_byte;

    assign bit_done  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_byte = (byte_cnt == BW'(NBYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = FETCH;
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = START;
            START:   if (bit_done) state_nxt = DATA;
            DATA:    if (bit_done && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:    if (bit_done) state_nxt = last_byte ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx      = 1'b1;
        read_en = 1'b0;
        busy    = (state != IDLE);
        case (state)
            FETCH:   read_en = 1'b1;
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            default: ;
        endcase
    end

    // Restarting on every state change keeps each bit exactly CLKS_PER_BIT long.
    always_ff @(posedge clk) begin
        if (rst)
            baud_cnt <= '0;
        else if (state_nxt != state || bit_done)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    // The word register shifts down a byte per frame, so byte[index] is always
    // its low byte when START hands over to DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg   <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            words_sent <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    word_reg <= data_in;
                    byte_cnt <= '0;
                end
                START: if (bit_done) begin
                    shreg    <= word_reg[7:0];
                    word_reg <= word_reg >> 8;
                    bit_cnt  <= '0;
                end
                DATA: if (bit_done) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                STOP: if (bit_done) begin
                    if (last_byte) words_sent <= words_sent + 16'd1;
                    else           byte_cnt   <= byte_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4: logs tx every cycle,
// decodes frames from the log and checks bytes, timing, pops and counters.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst, fifo_empty, read_en, tx, busy;
    logic [15:0] data_in, words_sent;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          txlog[$];
    int          re_idx[$];
    logic [15:0] fifo_q[$];
    logic [7:0]  bytes[$];
    int          starts[$];
    int          stops_bad;

    fifo_uart_tx #(.DATA_LEN(16), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .read_en    (read_en),
        .data_in    (data_in),
        .tx         (tx),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        txlog.delete();
        re_idx.delete();
    endtask

    // One cycle per step: log tx, serve pops from the FIFO model.
    task automatic run_cycles(input int n, input bit toggle_empty);
        for (int c = 0; c < n; c++) begin
            tick();
            txlog.push_back(tx);
            if (read_en === 1'b1) begin
                re_idx.push_back(txlog.size() - 1);
                if (fifo_q.size() > 0) data_in = fifo_q.pop_front();
                if (fifo_q.size() == 0) fifo_empty = 1'b1;
            end
            if (toggle_empty) fifo_empty = ~fifo_empty;
        end
    endtask

    task automatic decode();
        int i;
        logic [7:0] b;
        bytes.delete();
        starts.delete();
        stops_bad = 0;
        i = 1;
        while (i < txlog.size()) begin
            if (txlog[i-1] && !txlog[i] && (i + 10*CPB <= txlog.size())) begin
                for (int k = 0; k < 8; k++) b[k] = txlog[i + CPB*(k+1) + CPB/2];
                if (!txlog[i + 9*CPB + CPB/2]) stops_bad++;
                starts.push_back(i);
                bytes.push_back(b);
                i += 10*CPB;
            end else begin
                i++;
            end
        end
    endtask

    function automatic int zeros();
        int z = 0;
        foreach (txlog[j]) if (!txlog[j]) z++;
        return z;
    endfunction

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b0;
        data_in    = 16'h0000;
        fifo_q     = {16'hA55A};

        // Reset held for 3 cycles with a non-empty FIFO
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_outs", {tx, read_en, busy}, {1'b1, 1'b0, 1'b0});
            chk("rst_words", words_sent, 16'h0000);
        end
        rst = 1'b0;
        chk("rel_idle_re", read_en, 1'b0);

        // Single word 0xA55A
        clear_logs();
        run_cycles(100, 1'b0);
        decode();
        chk("sw_pops", re_idx.size(), 1);
        chk("sw_pop_cycle", re_idx[0], 0);
        chk("sw_nbytes", bytes.size(), 2);
        chk("sw_byte0", bytes[0], 8'h5A);
        chk("sw_byte1", bytes[1], 8'hA5);
        chk("sw_stops", stops_bad, 0);
        chk("sw_latency", starts[0] - re_idx[0], 2);
        chk("sw_span", (starts[1] + 10*CPB) - starts[0], 80);
        chk("sw_low_cycles", zeros(), 40);
        chk("sw_words", words_sent, 16'd1);
        chk("sw_busy", busy, 1'b0);

        // Empty FIFO: nothing happens for 200 cycles
        clear_logs();
        run_cycles(200, 1'b0);
        chk("em_pops", re_idx.size(), 0);
        chk("em_low_cycles", zeros(), 0);
        chk("em_busy", busy, 1'b0);

        // Back-to-back words after a fresh reset
        rst = 1'b1;
        tick();
        chk("b2b_rst_words", words_sent, 16'h0000);
        rst        = 1'b0;
        fifo_q     = {16'h0001, 16'h8000, 16'hFFFF};
        fifo_empty = 1'b0;
        clear_logs();
        run_cycles(300, 1'b0);
        decode();
        chk("b2b_pops", re_idx.size(), 3);
        chk("b2b_nbytes", bytes.size(), 6);
        chk("b2b_bytes_lo", {bytes[0], bytes[1], bytes[2]}, 24'h010000);
        chk("b2b_bytes_hi", {bytes[3], bytes[4], bytes[5]}, 24'h80FFFF);
        chk("b2b_stops", stops_bad, 0);
        chk("b2b_gap1", starts[2] - (starts[1] + 10*CPB), 3);
        chk("b2b_gap2", starts[4] - (starts[3] + 10*CPB), 3);
        chk("b2b_words", words_sent, 16'd3);
        chk("b2b_busy", busy, 1'b0);

        // Reset during bit 3 of the second byte (0x12, bit 3 = 0)
        fifo_q     = {16'h1234};
        fifo_empty = 1'b0;
        clear_logs();
        run_cycles(59, 1'b0);
        chk("mid_pre_tx", txlog[58], 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_words", words_sent, 16'h0000);
        rst        = 1'b0;
        fifo_q     = {16'hC3A7};
        fifo_empty = 1'b0;
        clear_logs();
        run_cycles(100, 1'b0);
        decode();
        chk("mid_fresh_nbytes", bytes.size(), 2);
        chk("mid_fresh_bytes", {bytes[1], bytes[0]}, 16'hC3A7);
        chk("mid_fresh_words", words_sent, 16'd1);

        // Counter wrap, with fifo_empty toggling mid-word
        force dut.words_sent = 16'hFFFF;
        tick();
        release dut.words_sent;
        tick();
        chk("wr_preload", words_sent, 16'hFFFF);
        fifo_q     = {16'h5AA5};
        fifo_empty = 1'b0;
        clear_logs();
        run_cycles(10, 1'b0);
        run_cycles(20, 1'b1);
        run_cycles(70, 1'b0);
        decode();
        chk("wr_pops", re_idx.size(), 1);
        chk("wr_bytes", {bytes[1], bytes[0]}, 16'h5AA5);
        chk("wr_words", words_sent, 16'h0000);
        chk("wr_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
